// File: rtl/pkt_switch_pkg.sv
// Shared packet type and route-table helpers for the packet crossbar switch.
package pkt_switch_pkg;

    typedef struct packed {
        logic [7:0]  dest_id;
        logic [7:0]  src_id;
        logic [15:0] payload;
    } pkt_t;

    localparam int PKT_W         = $bits(pkt_t);
    localparam int ROUTE_W       = 4;
    localparam int ROUTE_ENTRIES = 16;

    // Only the low nibble of the destination selects a table entry.
    function automatic logic [ROUTE_W-1:0] route_lookup(
        input logic [ROUTE_ENTRIES*ROUTE_W-1:0] map,
        input logic [3:0]                       dest_lsb
    );
        return map[dest_lsb*ROUTE_W +: ROUTE_W];
    endfunction

endpackage

// File: rtl/pkt_switch_rr_arbiter.sv
// Round-robin arbiter: search starts at the stored pointer and wraps; the
// pointer moves past the winner only when a grant is actually issued.
module pkt_switch_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int             PW   = $clog2(N);
    localparam logic [PW:0]    N_W  = (PW+1)'(N);
    localparam logic [PW-1:0]  LAST = PW'(N-1);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_found;
    logic [PW:0]   w_cand;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_cand >= N_W) begin
                w_cand = w_cand - N_W;
            end
            if (!w_found && req[w_cand[PW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[PW-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (en && w_found) begin
            gnt[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_ptr <= '0;
        end else if (en && w_found) begin
            r_ptr <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pkt_switch.sv
// Packet crossbar: per-input packet FIFOs, table-driven routing, and one
// round-robin arbiter plus registered output slot per output port.
module pkt_switch
    import pkt_switch_pkg::*;
#(
    parameter int          NPORTS    = 4,
    parameter int          DEPTH     = 4,
    parameter logic [63:0] ROUTE_MAP = 64'h0
) (
    input  logic                                clk,
    input  logic                                rst_b,
    input  logic [NPORTS-1:0]                   in_valid,
    input  logic [NPORTS*PKT_W-1:0]             in_pkt,
    output logic [NPORTS-1:0]                   in_ready,
    output logic [NPORTS-1:0]                   out_valid,
    output logic [NPORTS*PKT_W-1:0]             out_pkt,
    input  logic [NPORTS-1:0]                   out_ready,
    output logic [NPORTS-1:0]                   drop,
    output logic [NPORTS*$clog2(DEPTH+1)-1:0]   in_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    pkt_t              r_mem      [NPORTS][DEPTH];
    logic [AW:0]       r_wr_ptr   [NPORTS];
    logic [AW:0]       r_rd_ptr   [NPORTS];
    pkt_t              r_out_pkt  [NPORTS];
    logic [NPORTS-1:0] r_out_valid;

    pkt_t               w_in_pkt [NPORTS];
    pkt_t               w_head   [NPORTS];
    pkt_t               w_sel    [NPORTS];
    logic [ROUTE_W-1:0] w_route  [NPORTS];
    logic [NPORTS-1:0]  w_req    [NPORTS];
    logic [NPORTS-1:0]  w_gnt    [NPORTS];
    logic [NPORTS-1:0]  w_empty;
    logic [NPORTS-1:0]  w_full;
    logic [NPORTS-1:0]  w_push;
    logic [NPORTS-1:0]  w_pop;
    logic [NPORTS-1:0]  w_drop;
    logic [NPORTS-1:0]  w_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        assign w_in_pkt[i] = in_pkt[i*PKT_W +: PKT_W];
        assign w_empty[i]  = (r_wr_ptr[i] == r_rd_ptr[i]);
        assign w_full[i]   = (r_wr_ptr[i][AW] != r_rd_ptr[i][AW]) &&
                             (r_wr_ptr[i][AW-1:0] == r_rd_ptr[i][AW-1:0]);
        assign w_head[i]   = r_mem[i][r_rd_ptr[i][AW-1:0]];
        assign w_route[i]  = route_lookup(ROUTE_MAP, w_head[i].dest_id[3:0]);
        assign w_drop[i]   = !w_empty[i] && (w_route[i] >= ROUTE_W'(NPORTS));
        assign in_count[i*CNT_W +: CNT_W] = CNT_W'(r_wr_ptr[i] - r_rd_ptr[i]);
    end

    assign w_push    = in_valid & ~w_full;
    assign in_ready  = ~w_full;
    assign drop      = w_drop;
    assign out_valid = r_out_valid;
    // A slot can take a packet when empty or when it drains this cycle.
    assign w_en      = ~r_out_valid | out_ready;

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            w_req[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                w_req[o][i] = !w_empty[i] && (w_route[i] == ROUTE_W'(o));
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        pkt_switch_rr_arbiter #(.N(NPORTS)) u_arb (
            .clk   (clk),
            .rst_b (rst_b),
            .req   (w_req[o]),
            .en    (w_en[o]),
            .gnt   (w_gnt[o])
        );
        assign out_pkt[o*PKT_W +: PKT_W] = r_out_pkt[o];
    end

    always_comb begin
        w_pop = w_drop;
        for (int o = 0; o < NPORTS; o++) begin
            w_sel[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (w_gnt[o][i]) begin
                    w_sel[o] = w_head[i];
                    w_pop[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            for (int i = 0; i < NPORTS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (w_push[i]) r_mem[i][r_wr_ptr[i][AW-1:0]] <= w_in_pkt[i];
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_out_valid <= '0;
            for (int o = 0; o < NPORTS; o++) r_out_pkt[o] <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (w_en[o]) begin
                    r_out_valid[o] <= |w_gnt[o];
                    if (|w_gnt[o]) r_out_pkt[o] <= w_sel[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_switch.sv
// Directed bench for pkt_switch: a driver pushes packets and queues the
// expected output per port; a monitor pops and compares on every transfer.
`timescale 1ns/1ps
module tb_pkt_switch;
  import pkt_switch_pkg::*;

  localparam int NP    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  // dest 0->0, 1->1, 2->3, 3->2, 4->0, 5->4 (unroutable), 6..15 -> F
  localparam logic [63:0] MAP = 64'hFFFF_FFFF_FF40_2310;

  logic clk = 1'b0;
  logic rst_b;
  logic [NP-1:0] in_valid, in_ready, out_valid, out_ready, drop;
  logic [NP*PKT_W-1:0] in_pkt, out_pkt;
  logic [NP*CW-1:0] in_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PKT_W-1:0] exp_q [NP][$];
  int drop_seen [NP];
  logic [NP-1:0] stall_prev;
  logic [PKT_W-1:0] stall_pkt [NP];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pkt_switch #(.NPORTS(NP), .DEPTH(DEPTH), .ROUTE_MAP(MAP)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_pkt    (in_pkt),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pkt   (out_pkt),
    .out_ready (out_ready),
    .drop      (drop),
    .in_count  (in_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk(input logic [7:0] dest, input logic [7:0] src,
                                          input logic [15:0] pay);
    return {dest, src, pay};
  endfunction

  function automatic logic [CW-1:0] cnt(input int p);
    return in_count[p*CW +: CW];
  endfunction

  function automatic logic is_idle();
    logic r;
    r = (in_count == '0) && (out_valid == '0);
    for (int o = 0; o < NP; o++) if (exp_q[o].size() != 0) r = 1'b0;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int p, input logic v, input logic [PKT_W-1:0] pk);
    in_valid[p] = v;
    in_pkt[p*PKT_W +: PKT_W] = pk;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!is_idle() && k < 200) begin
      @(negedge clk);
      #2;
      k++;
    end
    n_tests++;
    if (!is_idle()) begin
      n_fail++;
      $display("FAIL %s_idle: still busy after %0d cycles, expected drained", name, k);
    end
    @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    stall_prev = '0;
    for (int i = 0; i < NP; i++) drop_seen[i] = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_b) begin
        stall_prev = '0;
      end else begin
        for (int o = 0; o < NP; o++) begin
          if (stall_prev[o]) begin
            check($sformatf("hold_valid%0d", o), out_valid[o], 1'b1);
            check($sformatf("hold_pkt%0d", o), out_pkt[o*PKT_W +: PKT_W], stall_pkt[o]);
          end
          if (out_valid[o] && out_ready[o]) begin
            if (exp_q[o].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL out%0d_unexpected: got %h, expected no packet", o,
                       out_pkt[o*PKT_W +: PKT_W]);
            end else begin
              check($sformatf("out%0d_pkt", o), out_pkt[o*PKT_W +: PKT_W], exp_q[o].pop_front());
            end
          end
          stall_prev[o] = out_valid[o] && !out_ready[o];
          stall_pkt[o]  = out_pkt[o*PKT_W +: PKT_W];
          if (drop[o]) drop_seen[o]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [PKT_W-1:0] pk, pa, pb;
    in_valid  = '0;
    in_pkt    = '0;
    out_ready = '0;
    rst_b     = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_count", in_count, 0);
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_drop", drop, 0);
    check("rst_out_pkt_nz", |out_pkt, 0);

    // Single packet dest 2 on port 1 -> output 3, two-cycle latency
    out_ready = '1;
    pk = mk(8'h02, 8'h01, 16'hA5A5);
    set_in(1, 1'b1, pk);
    exp_q[3].push_back(pk);
    @(negedge clk);
    set_in(1, 1'b0, '0);
    check("lat_n1_valid", out_valid[3], 0);
    check("lat_n1_count", cnt(1), 1);
    @(negedge clk);
    check("lat_n2_valid", out_valid[3], 1);
    check("lat_drop", drop, 0);
    wait_idle("latency");

    // Four inputs contend for output 2: served 0,1,2,3,0,1,2,3
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < NP; p++) begin
        pk = mk(8'h03, 8'(p), 16'(16'h3000 + s*16 + p));
        set_in(p, 1'b1, pk);
        exp_q[2].push_back(pk);
      end
      @(negedge clk);
    end
    in_valid = '0;
    wait_idle("rr4");

    // Fill port 0 with the output stalled: slot + DEPTH entries accepted
    out_ready[0] = 1'b0;
    for (int k = 0; k < DEPTH+2; k++) begin
      pk = mk(8'h00, 8'h00, 16'(16'h4000 + k));
      set_in(0, 1'b1, pk);
      check($sformatf("fill_ready%0d", k), in_ready[0], (k < DEPTH+1));
      if (k < DEPTH+1) exp_q[0].push_back(pk);
      @(negedge clk);
    end
    set_in(0, 1'b0, '0);
    check("fill_count", cnt(0), DEPTH);
    check("fill_ready_low", in_ready[0], 0);
    check("fill_slot_valid", out_valid[0], 1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("fill_ready_back", in_ready[0], 1);
    check("fill_count_pop", cnt(0), DEPTH-1);
    wait_idle("fill");

    // Unroutable head (dest 0x25 -> entry 5 = 4) is dropped on port 2
    set_in(2, 1'b1, mk(8'h25, 8'h02, 16'h5005));
    @(negedge clk);
    set_in(2, 1'b0, '0);
    check("drop_pulse", drop, 4'b0100);
    check("drop_count1", cnt(2), 1);
    check("drop_no_valid1", out_valid, 0);
    @(negedge clk);
    check("drop_clear", drop, 0);
    check("drop_count0", cnt(2), 0);
    check("drop_no_valid2", out_valid, 0);
    wait_idle("drop");

    // U-turn: dest 0xF1 (entry 1) on port 1 leaves on output 1
    pk = mk(8'hF1, 8'h01, 16'h6161);
    set_in(1, 1'b1, pk);
    exp_q[1].push_back(pk);
    @(negedge clk);
    set_in(1, 1'b0, '0);
    wait_idle("uturn");

    // Ports 1 and 3 contend for output 0 (pointer now at 1) with ready toggling
    for (int k = 0; k < 16; k++) begin
      out_ready[0] = (k % 2 == 0);
      if (k < 3) begin
        pa = mk(8'h04, 8'h01, 16'(16'h7100 + k));
        pb = mk(8'h04, 8'h03, 16'(16'h7300 + k));
        set_in(1, 1'b1, pa);
        set_in(3, 1'b1, pb);
        exp_q[0].push_back(pa);
        exp_q[0].push_back(pb);
      end else begin
        in_valid = '0;
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    wait_idle("toggle");

    // Reset with a slotted packet and 3 buffered on port 0: all discarded
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1'b1, mk(8'h00, 8'h00, 16'(16'h8000 + k)));
      @(negedge clk);
    end
    set_in(0, 1'b0, '0);
    check("pre_rst_count", cnt(0), 3);
    check("pre_rst_valid", out_valid[0], 1);
    rst_b = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_count", in_count, 0);
    @(negedge clk);
    rst_b = 1'b0;
    out_ready = '1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 4'hF);
    check("post_rst_count", in_count, 0);
    repeat (10) @(negedge clk);
    check("post_rst_no_valid", out_valid, 0);
    pk = mk(8'h00, 8'h02, 16'h9999);
    set_in(2, 1'b1, pk);
    exp_q[0].push_back(pk);
    @(negedge clk);
    set_in(2, 1'b0, '0);
    wait_idle("post_rst");

    // Drop pulses seen by the monitor across the whole run
    for (int p = 0; p < NP; p++) begin
      check($sformatf("drop_total%0d", p), drop_seen[p], (p == 2) ? 1 : 0);
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
